jeff_74x157_arbiter: RTL and testbench
======================================

# jeff_74x157_arbiter

Two-requester round-robin arbiter that shares a single quad 2-to-1 multiplexer (jeff_74x157) between requester A (mux input a) and requester B (mux input b). It sequences the mux select and enable pins from a req/gnt handshake and bounds each grant with a hold limit so neither requester can starve the other. It sits directly beside the mux: its mux_s and mux_en outputs connect to the mux s and en pins.

## Interface
- MAX_HOLD, 4: maximum grant length in cycles while the other side is requesting; legal range 1..15.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- req_a  input  1  requester A wants the mux; held high for as long as it needs the mux.
- req_b  input  1  requester B wants the mux; same rules as req_a.
- gnt_a  output  1  A owns the mux this cycle (registered).
- gnt_b  output  1  B owns the mux this cycle (registered).
- mux_s  output  1  mux select: 0 selects a, 1 selects b (registered).
- mux_en  output  1  mux enable, active-high disable: 1 forces mux y=0 (registered).
- busy  output  1  high whenever either grant is high.

## Operation
- States:
  - IDLE: gnt_a=0, gnt_b=0, mux_s=0, mux_en=1.
  - GRANT_A: gnt_a=1, mux_s=0, mux_en=0.
  - GRANT_B: gnt_b=1, mux_s=1, mux_en=0.
- All outputs decode from the registered state; there is no combinational path from req to any output.
- A last-owner flag records the last granted side. Reset value is B, so A wins the first tie.
- IDLE transitions:
  - Only req_a high → GRANT_A.
  - Only req_b high → GRANT_B.
  - Both high → the side that is not the last owner.
  - Neither high → stay in IDLE.
- GRANT_A transitions (GRANT_B is symmetric):
  - req_a low → GRANT_B if req_b is high, else IDLE.
  - req_a high, hold counter = MAX_HOLD-1, and req_b high → GRANT_B (preemption).
  - Otherwise stay in GRANT_A.
- Hold counter:
  - 4 bits wide.
  - Cleared on every entry to a grant state, including a direct A↔B switch.
  - Increments each cycle the grant is kept.
  - Saturates at MAX_HOLD-1, so a lone requester keeps the mux indefinitely.
- Last-owner flag updates on every entry to GRANT_A or GRANT_B.
- Grants are mutually exclusive; gnt_a and gnt_b are never both high.
- A↔B switches happen directly, with no IDLE bubble. mux_s toggles and mux_en stays 0.
- Reset mid-grant: the state returns to IDLE on the next edge regardless of requests. Reset also clears the counter and sets last-owner to B.

## Timing
- Reset values: gnt_a=0, gnt_b=0, mux_s=0, mux_en=1, busy=0.
- Grant latency: a req sampled high at edge N in IDLE gives a grant visible after edge N. Outputs change one cycle after the request.
- Release latency: a req sampled low at edge N drops the grant after edge N.
- Requester rules:
  - Drive mux data only while its gnt is high.
  - Keep req high until done.
  - Dropping req is the release.
- Maximum grant length under contention is MAX_HOLD cycles. With MAX_HOLD=1 and continuous contention, ownership alternates A, B, A, … every cycle.
- Simultaneous release and arrival (req_a falls while req_b rises at the same edge) → GRANT_B at that edge.
- req_a and req_b rising together at the first edge after reset → GRANT_A.

## Test plan
- Reset: hold rst=1 for 2 cycles with req_a=req_b=1 → gnt_a=0, gnt_b=0, mux_en=1, mux_s=0. Release rst → gnt_a=1 one cycle later.
- Lone requester: req_a=1 for 10 cycles (MAX_HOLD=4), req_b=0 → gnt_a stays 1 for all 10 cycles, mux_s=0, mux_en=0. Drop req_a → IDLE and mux_en=1 next cycle.
- Contention: req_a=req_b=1 continuously (MAX_HOLD=4) → gnt_a for 4 cycles, then gnt_b for 4, repeating. mux_s toggles 0→1→0 with no mux_en=1 cycle. Checker drives a=4'ha, b=4'h5 and sees the mux y sequence ha×4, h5×4.
- Early release: in GRANT_A after 1 cycle, drop req_a with req_b=1 → gnt_b on the next cycle, and its hold count restarts (B keeps the mux for 4 cycles if A re-requests).
- Round-robin tie: after a B grant ends and the arbiter returns to IDLE, raise req_a and req_b together → GRANT_A. Repeat after an A grant ends → GRANT_B.
- Reset mid-grant: assert rst during GRANT_B, cycle 2 → IDLE next edge, counter=0. After release with both requesting → GRANT_A.

Source files
------------

// File: rtl/jeff_74x157_arbiter.sv
// rtl/jeff_74x157_arbiter.sv - two-requester round-robin arbiter driving a 74x157 mux
// Hold limit bounds each grant while the other side waits; all outputs are flops.
module jeff_74x157_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b,
  output logic mux_s,
  output logic mux_en,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_b_q, last_b_d;
  logic       gnt_a_q, gnt_a_d;
  logic       gnt_b_q, gnt_b_d;
  logic       mux_s_q, mux_s_d;
  logic       mux_en_q, mux_en_d;
  logic       busy_q, busy_d;
  logic       entering;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_a && (!req_b || last_b_q)) state_d = GRANT_A;
        else if (req_b)                    state_d = GRANT_B;
      end
      GRANT_A: begin
        if (!req_a)                              state_d = req_b ? GRANT_B : IDLE;
        else if (req_b && (cnt_q == HOLD_LAST))  state_d = GRANT_B;
      end
      GRANT_B: begin
        if (!req_b)                              state_d = req_a ? GRANT_A : IDLE;
        else if (req_a && (cnt_q == HOLD_LAST))  state_d = GRANT_A;
      end
      default: state_d = IDLE;
    endcase

    // A direct A<->B switch counts as a fresh entry, so the counter restarts.
    entering = (state_d != state_q) && (state_d != IDLE);

    cnt_d = cnt_q;
    if (entering || (state_d == IDLE)) cnt_d = 4'd0;
    else if (cnt_q != HOLD_LAST)       cnt_d = cnt_q + 4'd1;

    last_b_d = entering ? (state_d == GRANT_B) : last_b_q;

    // Outputs are decoded from the next state and registered alongside it.
    gnt_a_d  = (state_d == GRANT_A);
    gnt_b_d  = (state_d == GRANT_B);
    mux_s_d  = (state_d == GRANT_B);
    mux_en_d = (state_d == IDLE);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      last_b_q <= 1'b1;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      mux_s_q  <= 1'b0;
      mux_en_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_b_q <= last_b_d;
      gnt_a_q  <= gnt_a_d;
      gnt_b_q  <= gnt_b_d;
      mux_s_q  <= mux_s_d;
      mux_en_q <= mux_en_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt_a  = gnt_a_q;
  assign gnt_b  = gnt_b_q;
  assign mux_s  = mux_s_q;
  assign mux_en = mux_en_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_jeff_74x157_arbiter.sv
// tb/tb_jeff_74x157_arbiter.sv - bench for jeff_74x157_arbiter
module tb_jeff_74x157_arbiter;

  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst, req_a, req_b;
  logic gnt_a, gnt_b, mux_s, mux_en, busy;
  logic [3:0] da, db;

  int total = 0;
  int bad   = 0;

  // Reference: who owns the mux, how many cycles it has owned it, who owned it last.
  int own  = 0;   // 0 none, 1 A, 2 B
  int held = 0;
  int last = 2;

  jeff_74x157_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .mux_s(mux_s), .mux_en(mux_en), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_edge(input bit ra, input bit rb, input bit r);
    int nxt;
    bit mine, other;
    if (r) begin
      own = 0; held = 0; last = 2;
      return;
    end
    if (own == 0) begin
      if (ra && rb) nxt = (last == 1) ? 2 : 1;
      else if (ra)  nxt = 1;
      else if (rb)  nxt = 2;
      else          nxt = 0;
    end else begin
      mine  = (own == 1) ? ra : rb;
      other = (own == 1) ? rb : ra;
      if (!mine)                        nxt = other ? 3 - own : 0;
      else if (other && held >= MAX_HOLD) nxt = 3 - own;
      else                              nxt = own;
    end
    if (nxt == 0)        held = 0;
    else if (nxt != own) begin held = 1; last = nxt; end
    else                 held++;
    own = nxt;
  endtask

  task automatic step(input bit ra, input bit rb, input bit r);
    logic [3:0] y_obs, y_exp;
    rst = r; req_a = ra; req_b = rb;
    @(posedge clk);
    model_edge(ra, rb, r);
    #1;
    chk("gnt_a",  {3'b0, gnt_a},  {3'b0, own == 1});
    chk("gnt_b",  {3'b0, gnt_b},  {3'b0, own == 2});
    chk("mux_s",  {3'b0, mux_s},  {3'b0, own == 2});
    chk("mux_en", {3'b0, mux_en}, {3'b0, own == 0});
    chk("busy",   {3'b0, busy},   {3'b0, own != 0});
    // 74x157 behaviour: enable high forces y low, otherwise select picks a or b.
    y_obs = mux_en ? 4'h0 : (mux_s ? db : da);
    y_exp = (own == 1) ? da : (own == 2) ? db : 4'h0;
    chk("mux_y", y_obs, y_exp);
  endtask

  initial begin
    bit ra, rb, r;
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    da = 4'ha; db = 4'h5;

    step(1, 1, 1);
    step(1, 1, 1);
    for (int i = 0; i < 16; i++) step(1, 1, 0);
    step(0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 1, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 1);
    step(1, 1, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    step(1, 0, 0);

    ra = 0; rb = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(9) < 2) ra = ~ra;
      if ($urandom_range(9) < 2) rb = ~rb;
      r = ($urandom_range(99) < 2);
      da = 4'($urandom);
      db = 4'($urandom);
      step(ra, rb, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
